// File: rtl/load_ext_pkg.sv
// Shared definitions for the load-data formatter: funct3 encodings,
// buffer state encoding and the result record held in the output buffer.
package load_ext_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Result record fields are sized for the widest supported configuration
    // (XLEN=64, tags up to 16 bits); narrower units use the low bits.
    localparam int LR_DATA_W = 64;
    localparam int LR_TAG_W  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [LR_DATA_W-1:0] data;
        logic [LR_TAG_W-1:0]  tag;
        logic                 misalign;
        logic                 illegal;
    } load_res_t;

endpackage

// File: rtl/sign_ext_var.sv
// Variable-size extender: keeps the low (8 << Size) bits of In and fills
// the rest with the top kept bit (Signed=1) or zeros (Signed=0).
module sign_ext_var #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] In,
    input  logic [1:0]      Size,
    input  logic            Signed,
    output logic [XLEN-1:0] Out
);

    int   kept;
    logic top;

    // Pick the sign bit of the kept field, then fill bit-by-bit above it
    always_comb begin
        kept = 8 << Size;
        case (Size)
            2'd0:    top = In[7];
            2'd1:    top = In[15];
            2'd2:    top = In[31];
            default: top = In[XLEN-1];
        endcase
        Out = '0;
        for (int i = 0; i < XLEN; i++) begin
            Out[i] = (i < kept) ? In[i] : (Signed & top);
        end
    end

endmodule

// File: rtl/load_ext_unit.sv
// Pipelined load-data formatter: byte shift, size/sign extension and
// misalign/illegal flagging, registered behind a 2-entry skid buffer.
//
// Handshake: a transfer happens on a rising edge where valid && ready on
// that side. Out_* stay stable while Out_Valid=1 and Out_Ready=0. In_Ready
// depends only on the buffer state, never combinationally on Out_Ready.
module load_ext_unit
    import load_ext_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       In_Valid,
    output logic                       In_Ready,
    input  logic [XLEN-1:0]            In_Data,
    input  logic [$clog2(XLEN/8)-1:0]  In_Off,
    input  logic [2:0]                 In_Funct3,
    input  logic [TAG_W-1:0]           In_Tag,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic [XLEN-1:0]            Out_Data,
    output logic [TAG_W-1:0]           Out_Tag,
    output logic                       Out_Misalign,
    output logic                       Out_Illegal,
    output logic [1:0]                 dbg_state
);

    localparam int OFF_W = $clog2(XLEN/8);

    logic [1:0]      size_lg;
    logic            sgn;
    logic            illegal;
    logic            misalign;
    logic [OFF_W-1:0] off_mask;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ext;
    load_res_t       nxt;

    buf_state_e      state;
    load_res_t       main_q;
    load_res_t       skid_q;
    logic            in_fire;
    logic            out_fire;
    logic            unused_bits;

    // Decode funct3 into access size, signedness and legality
    always_comb begin
        size_lg = 2'd0;
        sgn     = 1'b1;
        illegal = 1'b0;
        case (In_Funct3)
            F3_LB:   begin size_lg = 2'd0; sgn = 1'b1; end
            F3_LH:   begin size_lg = 2'd1; sgn = 1'b1; end
            F3_LW:   begin size_lg = 2'd2; sgn = 1'b1; end
            F3_LD:   begin size_lg = 2'd3; sgn = 1'b1; illegal = (XLEN != 64); end
            F3_LBU:  begin size_lg = 2'd0; sgn = 1'b0; end
            F3_LHU:  begin size_lg = 2'd1; sgn = 1'b0; end
            F3_LWU:  begin size_lg = 2'd2; sgn = 1'b0; illegal = (XLEN != 64); end
            default: illegal = 1'b1;
        endcase
    end

    assign shifted = In_Data >> {In_Off, 3'b000};

    sign_ext_var #(.XLEN(XLEN)) u_ext (
        .In     (shifted),
        .Size   (size_lg),
        .Signed (sgn),
        .Out    (ext)
    );

    // Misalign check and error precedence (illegal masks misalign)
    always_comb begin
        off_mask     = OFF_W'((4'd1 << size_lg) - 4'd1);
        misalign     = (In_Off & off_mask) != '0;
        nxt          = '0;
        nxt.tag      = LR_TAG_W'(In_Tag);
        nxt.illegal  = illegal;
        nxt.misalign = !illegal && misalign;
        nxt.data     = (illegal || misalign) ? '0 : LR_DATA_W'(ext);
    end

    assign in_fire  = In_Valid && In_Ready;
    assign out_fire = Out_Valid && Out_Ready;

    // Skid buffer FSM: main holds the oldest entry, skid the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_q <= nxt;
                        state  <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_q <= nxt;
                        state  <= ST_TWO;
                    end else if (!in_fire && out_fire) begin
                        state  <= ST_EMPTY;
                    end else if (in_fire && out_fire) begin
                        main_q <= nxt;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign In_Ready     = (state != ST_TWO);
    assign Out_Valid    = (state != ST_EMPTY);
    assign Out_Data     = main_q.data[XLEN-1:0];
    assign Out_Tag      = main_q.tag[TAG_W-1:0];
    assign Out_Misalign = main_q.misalign;
    assign Out_Illegal  = main_q.illegal;
    assign dbg_state    = state;

    // Record bits above XLEN/TAG_W are never presented on the outputs
    assign unused_bits = ^{main_q.data, main_q.tag};

endmodule

// File: tb/tb_load_ext_unit.sv
// Bench for load_ext_unit: table of directed vectors applied to an XLEN=32
// and an XLEN=64 instance, plus backpressure and reset-in-TWO sequences.
module tb_load_ext_unit;
    import load_ext_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- XLEN=32 instance ----------------
    logic        i32_valid, o32_iready, o32_valid, i32_oready;
    logic [31:0] i32_data, o32_data;
    logic [1:0]  i32_off;
    logic [2:0]  i32_f3;
    logic [4:0]  i32_tag, o32_tag;
    logic        o32_mis, o32_ill;
    logic [1:0]  o32_state;

    load_ext_unit #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst),
        .In_Valid(i32_valid), .In_Ready(o32_iready), .In_Data(i32_data),
        .In_Off(i32_off), .In_Funct3(i32_f3), .In_Tag(i32_tag),
        .Out_Valid(o32_valid), .Out_Ready(i32_oready), .Out_Data(o32_data),
        .Out_Tag(o32_tag), .Out_Misalign(o32_mis), .Out_Illegal(o32_ill),
        .dbg_state(o32_state)
    );

    // ---------------- XLEN=64 instance ----------------
    logic        i64_valid, o64_iready, o64_valid, i64_oready;
    logic [63:0] i64_data, o64_data;
    logic [2:0]  i64_off;
    logic [2:0]  i64_f3;
    logic [4:0]  i64_tag, o64_tag;
    logic        o64_mis, o64_ill;
    logic [1:0]  o64_state;

    load_ext_unit #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst),
        .In_Valid(i64_valid), .In_Ready(o64_iready), .In_Data(i64_data),
        .In_Off(i64_off), .In_Funct3(i64_f3), .In_Tag(i64_tag),
        .Out_Valid(o64_valid), .Out_Ready(i64_oready), .Out_Data(o64_data),
        .Out_Tag(o64_tag), .Out_Misalign(o64_mis), .Out_Illegal(o64_ill),
        .dbg_state(o64_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [4:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive32(input logic v, input logic [31:0] d, input logic [1:0] off,
                           input logic [2:0] f3, input logic [4:0] tag);
        i32_valid = v; i32_data = d; i32_off = off; i32_f3 = f3; i32_tag = tag;
    endtask

    task automatic drive64(input logic v, input logic [63:0] d, input logic [2:0] off,
                           input logic [2:0] f3, input logic [4:0] tag);
        i64_valid = v; i64_data = d; i64_off = off; i64_f3 = f3; i64_tag = tag;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        sel64;
        logic [63:0] data;
        logic [2:0]  off;
        logic [2:0]  f3;
        logic [4:0]  tag;
        logic [63:0] exp_data;
        logic        exp_mis;
        logic        exp_ill;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs[NVEC];

    initial begin
        vecs[0]  = '{1'b0, 64'h80FF7F01, 3'd3, F3_LB,  5'd1,  64'hFFFFFF80, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 64'h80011234, 3'd2, F3_LHU, 5'd2,  64'h00008001, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 64'h80011234, 3'd2, F3_LH,  5'd3,  64'hFFFF8001, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 64'h12345678, 3'd1, F3_LW,  5'd4,  64'h0,        1'b1, 1'b0};
        vecs[4]  = '{1'b0, 64'h12345678, 3'd0, 3'b011, 5'd5,  64'h0,        1'b0, 1'b1};
        vecs[5]  = '{1'b0, 64'h12345678, 3'd3, F3_LW,  5'd6,  64'h0,        1'b1, 1'b0};
        vecs[6]  = '{1'b0, 64'hDEADBEEF, 3'd0, F3_LW,  5'd7,  64'hDEADBEEF, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 64'h80FF7F01, 3'd2, F3_LB,  5'd8,  64'hFFFFFFFF, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 64'h80FF7F01, 3'd2, F3_LBU, 5'd9,  64'h000000FF, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 64'h80FF7F01, 3'd1, F3_LBU, 5'd10, 64'h0000007F, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 64'h12345678, 3'd0, 3'b110, 5'd11, 64'h0,        1'b0, 1'b1};
        vecs[11] = '{1'b0, 64'h12345678, 3'd0, 3'b111, 5'd12, 64'h0,        1'b0, 1'b1};
        vecs[12] = '{1'b0, 64'h12345678, 3'd1, F3_LH,  5'd13, 64'h0,        1'b1, 1'b0};
        vecs[13] = '{1'b0, 64'h12345678, 3'd1, 3'b011, 5'd14, 64'h0,        1'b0, 1'b1};
        vecs[14] = '{1'b0, 64'h12345678, 3'd0, F3_LHU, 5'd15, 64'h00005678, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 64'hDEADBEEF80000000, 3'd4, F3_LWU, 5'd16, 64'h00000000DEADBEEF, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 64'hDEADBEEF80000000, 3'd0, F3_LD,  5'd17, 64'hDEADBEEF80000000, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 64'hDEADBEEF80000000, 3'd4, F3_LW,  5'd18, 64'hFFFFFFFFDEADBEEF, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 64'hDEADBEEF80000000, 3'd0, F3_LW,  5'd19, 64'hFFFFFFFF80000000, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 64'hDEADBEEF80000000, 3'd7, F3_LB,  5'd20, 64'hFFFFFFFFFFFFFFDE, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 64'hDEADBEEF80000000, 3'd4, F3_LD,  5'd21, 64'h0,               1'b1, 1'b0};
        vecs[21] = '{1'b1, 64'hDEADBEEF80000000, 3'd2, F3_LWU, 5'd22, 64'h0,               1'b1, 1'b0};
        vecs[22] = '{1'b1, 64'hDEADBEEF80000000, 3'd6, F3_LHU, 5'd23, 64'h000000000000DEAD, 1'b0, 1'b0};
        vecs[23] = '{1'b1, 64'hDEADBEEF80000000, 3'd0, 3'b111, 5'd24, 64'h0,               1'b0, 1'b1};
    end

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        i32_oready = 1'b1;
        i64_oready = 1'b1;
        drive32(1'b0, 32'h0, 2'd0, 3'd0, 5'd0);
        drive64(1'b0, 64'h0, 3'd0, 3'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst32_out_valid", 64'(o32_valid), 64'd0);
        check("rst32_in_ready",  64'(o32_iready), 64'd1);
        check("rst32_data",      64'(o32_data), 64'd0);
        check("rst32_tag",       64'(o32_tag), 64'd0);
        check("rst32_flags",     64'({o32_mis, o32_ill}), 64'd0);
        check("rst64_out_valid", 64'(o64_valid), 64'd0);
        check("rst64_data",      o64_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back stream with Out_Ready=1: one result per cycle, never TWO
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            if (vecs[i].sel64) begin
                drive64(1'b1, vecs[i].data, vecs[i].off, vecs[i].f3, vecs[i].tag);
                i32_valid = 1'b0;
            end else begin
                drive32(1'b1, vecs[i].data[31:0], vecs[i].off[1:0], vecs[i].f3, vecs[i].tag);
                i64_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (vecs[i].sel64) begin
                check($sformatf("v%0d_valid", i), 64'(o64_valid), 64'd1);
                check($sformatf("v%0d_data", i),  o64_data, vecs[i].exp_data);
                check($sformatf("v%0d_mis", i),   64'(o64_mis), 64'(vecs[i].exp_mis));
                check($sformatf("v%0d_ill", i),   64'(o64_ill), 64'(vecs[i].exp_ill));
                check($sformatf("v%0d_tag", i),   64'(o64_tag), 64'(vecs[i].tag));
                check($sformatf("v%0d_ready", i), 64'(o64_iready), 64'd1);
            end else begin
                check($sformatf("v%0d_valid", i), 64'(o32_valid), 64'd1);
                check($sformatf("v%0d_data", i),  64'(o32_data), vecs[i].exp_data);
                check($sformatf("v%0d_mis", i),   64'(o32_mis), 64'(vecs[i].exp_mis));
                check($sformatf("v%0d_ill", i),   64'(o32_ill), 64'(vecs[i].exp_ill));
                check($sformatf("v%0d_tag", i),   64'(o32_tag), 64'(vecs[i].tag));
                check($sformatf("v%0d_ready", i), 64'(o32_iready), 64'd1);
            end
        end
        @(negedge clk);
        i32_valid = 1'b0;
        i64_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain32_valid", 64'(o32_valid), 64'd0);
        check("drain64_valid", 64'(o64_valid), 64'd0);

        // Backpressure: tags 1,2,3 with Out_Ready=0
        @(negedge clk);
        i32_oready = 1'b0;
        drive32(1'b1, 32'h11111111, 2'd0, F3_LW, 5'd1);
        @(posedge clk);
        exp_q.push_back(5'd1);
        #1;
        check("bp1_in_ready", 64'(o32_iready), 64'd1);
        check("bp1_valid",    64'(o32_valid), 64'd1);
        @(negedge clk);
        drive32(1'b1, 32'h22222222, 2'd0, F3_LW, 5'd2);
        @(posedge clk);
        exp_q.push_back(5'd2);
        #1;
        check("bp2_in_ready", 64'(o32_iready), 64'd0);
        check("bp2_state",    64'(o32_state), 64'(ST_TWO));
        @(negedge clk);
        drive32(1'b1, 32'h33333333, 2'd0, F3_LW, 5'd3);
        @(posedge clk);
        #1;
        check("bp3_in_ready",    64'(o32_iready), 64'd0);
        check("bp3_stable_tag",  64'(o32_tag), 64'd1);
        check("bp3_stable_data", 64'(o32_data), 64'h11111111);
        @(negedge clk);
        i32_oready = 1'b1;
        check("bp_out_tag_a", 64'(o32_tag), 64'(exp_q.pop_front()));
        @(posedge clk);
        #1;
        check("bp_in_ready_back", 64'(o32_iready), 64'd1);
        @(negedge clk);
        check("bp_out_tag_b", 64'(o32_tag), 64'(exp_q.pop_front()));
        check("bp_out_data_b", 64'(o32_data), 64'h22222222);
        exp_q.push_back(5'd3);
        @(posedge clk);
        @(negedge clk);
        i32_valid = 1'b0;
        check("bp_out_valid_c", 64'(o32_valid), 64'd1);
        check("bp_out_tag_c", 64'(o32_tag), 64'(exp_q.pop_front()));
        check("bp_out_data_c", 64'(o32_data), 64'h33333333);
        @(posedge clk);
        #1;
        check("bp_empty_valid", 64'(o32_valid), 64'd0);
        check("bp_q_empty", 64'(exp_q.size()), 64'd0);

        // Reset while the buffer is in TWO
        @(negedge clk);
        i32_oready = 1'b0;
        drive32(1'b1, 32'hAAAA5555, 2'd0, F3_LW, 5'd9);
        @(posedge clk);
        @(negedge clk);
        drive32(1'b1, 32'h5555AAAA, 2'd0, F3_LW, 5'd10);
        @(posedge clk);
        #1;
        check("rst2_pre_state", 64'(o32_state), 64'(ST_TWO));
        @(negedge clk);
        rst = 1'b1;
        drive32(1'b1, 32'h77777777, 2'd0, F3_LW, 5'd17);
        @(posedge clk);
        #1;
        check("rst2_valid",    64'(o32_valid), 64'd0);
        check("rst2_in_ready", 64'(o32_iready), 64'd1);
        check("rst2_data",     64'(o32_data), 64'd0);
        check("rst2_tag",      64'(o32_tag), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        i32_valid = 1'b0;
        i32_oready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst2_quiet_valid%0d", c), 64'(o32_valid), 64'd0);
            check($sformatf("rst2_quiet_tag%0d", c),   64'(o32_tag), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
